// File: rtl/seq_scan_arbiter.sv
// Two-requester round-robin front end for a serial MSB-first "00" run detector.
// Optional abort input enabled by defining SEQ_SCAN_ABORT_EN.
module seq_scan_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SEQ_SCAN_ABORT_EN
  input  logic             abort,
`endif
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             seq_out,
  output logic             seq_valid,
  output logic             done,
  output logic             owner,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic [1:0]         grant_q, grant_d;
  logic               owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [BIT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [1:0]         z_q, z_d;

  logic               abort_hit;
  logic               winner;
  logic               scan_bit;
  logic               last_bit;

`ifdef SEQ_SCAN_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign winner   = req[ptr_q] ? ptr_q : ~ptr_q;
  assign scan_bit = sreg_q[WIDTH-1];
  assign last_bit = (bitcnt_q == LAST_BIT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every variable assigned in a combinational block gets a default first,
  // otherwise an unassigned path holds its old value and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (|req) state_d = S_SHIFT;
      S_SHIFT: begin
        if (abort_hit)     state_d = S_IDLE;
        else if (last_bit) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    seq_valid = (state_q == S_SHIFT);
    done      = (state_q == S_DONE);
    seq_out   = seq_valid & scan_bit;
  end

  // Datapath next-state: arbitration, word capture and the zero-run detector.
  always_comb begin
    ptr_d    = ptr_q;
    grant_d  = 2'b00;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    sreg_d   = sreg_q;
    bitcnt_d = bitcnt_q;
    z_d      = z_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          sreg_d   = winner ? data1 : data0;
          owner_d  = winner;
          grant_d  = winner ? 2'b10 : 2'b01;
          cnt_d    = '0;
          z_d      = 2'd0;
          bitcnt_d = '0;
        end
      end
      S_SHIFT: begin
        if (abort_hit) begin
          ptr_d = ~owner_q;
        end else begin
          sreg_d   = {sreg_q[WIDTH-2:0], 1'b0};
          bitcnt_d = bitcnt_q + 1'b1;
          if (!scan_bit) begin
            // z counts the zeros seen in a row, capped at 2; any z>=1 means a new pair.
            if ((z_q != 2'd0) && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
            z_d = (z_q == 2'd2) ? 2'd2 : z_q + 2'd1;
          end else begin
            z_d = 2'd0;
          end
        end
      end
      S_DONE: begin
        ptr_d = ~owner_q;
      end
      default: ;
    endcase
  end

  // NOTE: the shift register is a plain register, not a memory array, so it is
  // reset with everything else and seq_out is defined from the first cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= 1'b0;
      grant_q  <= 2'b00;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      sreg_q   <= '0;
      bitcnt_q <= '0;
      z_q      <= 2'd0;
    end else begin
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      sreg_q   <= sreg_d;
      bitcnt_q <= bitcnt_d;
      z_q      <= z_d;
    end
  end

  assign grant     = grant_q;
  assign owner     = owner_q;
  assign match_cnt = cnt_q;

endmodule
